i2s_tx: RTL and testbench

Serializes filtered stereo 24-bit samples (biquad/vocoder output stream) into a standard I2S frame for the external DAC. Generates BCLK and LRCLK by dividing the system clock. Accepts samples through a one-entry valid/ready holding buffer. Sits at the output end of the sample path, after the filter bank.

---
 rtl/i2s_tx.sv | 141 ++++++++++++++
 tb/tb_i2s_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk_in into BCLK/LRCLK and shifts out buffered stereo
// samples MSB first with the standard one-bit delay after each LRCLK change.
module i2s_tx #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_HALF    = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    input  logic                    sample_valid_in,
    output logic                    sample_ready_out,
    output logic                    bclk_out,
    output logic                    lrclk_out,
    output logic                    sdata_out,
    output logic                    underrun_out
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int PAD        = SLOT_WIDTH - SAMPLE_WIDTH;
    localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_WIDTH - 1);

    logic [DIV_W-1:0]        divCnt_q, divCnt_d;
    logic                    bclk_q, bclk_d;
    logic [CNT_W-1:0]        bitCnt_q, bitCnt_d;
    logic                    lrclk_q, lrclk_d;
    logic                    sdata_q, sdata_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    bufFull_q, bufFull_d;
    logic [SAMPLE_WIDTH-1:0] bufLeft_q, bufLeft_d;
    logic [SAMPLE_WIDTH-1:0] bufRight_q, bufRight_d;
    logic                    ready_q, ready_d;
    logic                    underrun_q, underrun_d;

    logic                    halfDone;
    logic                    fallEvent;
    logic                    frameStart;
    logic                    capture;
    logic [SLOT_WIDTH-1:0]   slotLeft;
    logic [SLOT_WIDTH-1:0]   slotRight;
    logic [FRAME_BITS-1:0]   frameWord;

    assign halfDone   = (divCnt_q == DIV_LAST);
    assign fallEvent  = halfDone && bclk_q;
    assign frameStart = fallEvent && (bitCnt_q == CNT_LAST);
    assign capture    = sample_valid_in && ready_q;

    // Each sample sits left-justified in its slot, zero padded below the LSB.
    assign slotLeft  = SLOT_WIDTH'(bufLeft_q) << PAD;
    assign slotRight = SLOT_WIDTH'(bufRight_q) << PAD;
    assign frameWord = {slotLeft, slotRight};

    always_comb begin
        divCnt_d   = divCnt_q;
        bclk_d     = bclk_q;
        bitCnt_d   = bitCnt_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        shift_d    = shift_q;
        bufFull_d  = bufFull_q;
        bufLeft_d  = bufLeft_q;
        bufRight_d = bufRight_q;
        underrun_d = 1'b0;

        if (halfDone) begin
            divCnt_d = '0;
            bclk_d   = ~bclk_q;
        end else begin
            divCnt_d = divCnt_q + DIV_W'(1);
        end

        // The MSB leaving the shifter on each event is the previous frame bit,
        // which yields the one-BCLK delay relative to LRCLK.
        if (fallEvent) begin
            bitCnt_d = (bitCnt_q == CNT_LAST) ? '0 : bitCnt_q + CNT_W'(1);
            lrclk_d  = (bitCnt_d > SLOT_LAST);
            sdata_d  = shift_q[FRAME_BITS-1];
            if (frameStart) begin
                if (bufFull_q) begin
                    shift_d   = frameWord;
                    bufFull_d = 1'b0;
                end else begin
                    shift_d    = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                shift_d = shift_q << 1;
            end
        end

        // Capture only happens while empty, so it never collides with a consume.
        if (capture) begin
            bufFull_d  = 1'b1;
            bufLeft_d  = left_in;
            bufRight_d = right_in;
        end

        ready_d = ~bufFull_d;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            divCnt_q   <= '0;
            bclk_q     <= 1'b0;
            bitCnt_q   <= CNT_LAST;
            lrclk_q    <= 1'b1;
            sdata_q    <= 1'b0;
            shift_q    <= '0;
            bufFull_q  <= 1'b0;
            bufLeft_q  <= '0;
            bufRight_q <= '0;
            ready_q    <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            divCnt_q   <= divCnt_d;
            bclk_q     <= bclk_d;
            bitCnt_q   <= bitCnt_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            shift_q    <= shift_d;
            bufFull_q  <= bufFull_d;
            bufLeft_q  <= bufLeft_d;
            bufRight_q <= bufRight_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    assign sample_ready_out = ready_q;
    assign bclk_out         = bclk_q;
    assign lrclk_out        = lrclk_q;
    assign sdata_out        = sdata_q;
    assign underrun_out     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: instance A (32-bit slots, BCLK_HALF=2) covers framing,
// handshake, underrun and reset; instance B (24-bit slots, BCLK_HALF=1) covers unpadded frames.
module tb_i2s_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, validA;
    logic [23:0] leftA, rightA;
    logic        readyA, bclkA, lrA, sdA, urA;

    logic        rstB, validB;
    logic [23:0] leftB, rightB;
    logic        readyB, bclkB, lrB, sdB, urB;

    int checks   = 0;
    int failures = 0;

    i2s_tx #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .BCLK_HALF(2)) dutA (
        .clk_in(clk), .rst_in(rstA), .left_in(leftA), .right_in(rightA),
        .sample_valid_in(validA), .sample_ready_out(readyA), .bclk_out(bclkA),
        .lrclk_out(lrA), .sdata_out(sdA), .underrun_out(urA)
    );

    i2s_tx #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(24), .BCLK_HALF(1)) dutB (
        .clk_in(clk), .rst_in(rstB), .left_in(leftB), .right_in(rightB),
        .sample_valid_in(validB), .sample_ready_out(readyB), .bclk_out(bclkB),
        .lrclk_out(lrB), .sdata_out(sdB), .underrun_out(urB)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [23:0] l, input logic [23:0] r);
        validA = v;
        leftA  = l;
        rightA = r;
    endtask

    // Starting just after a frame-start edge, samples each following falling-edge event.
    task automatic collectFrame(input int which, input int nBits, input int stepClks,
                                output logic [63:0] word, output int lrOnes,
                                output int rdyOnes, output int urOnes);
        word = '0; lrOnes = 0; rdyOnes = 0; urOnes = 0;
        for (int j = 1; j <= nBits; j++) begin
            step(stepClks);
            word    = {word[62:0], (which == 0) ? sdA : sdB};
            lrOnes  += int'((which == 0) ? lrA : lrB);
            rdyOnes += int'((which == 0) ? readyA : readyB);
            urOnes  += int'((which == 0) ? urA : urB);
        end
    endtask

    function automatic logic [23:0] rampL(input int k);
        return 24'(k) << 20;
    endfunction

    logic [63:0] word;
    int lrOnes, rdyOnes, urOnes;
    int toggles, urCount, sdOnes;
    logic prevBclk, lr131, lr132;

    initial begin
        rstA = 1'b1; rstB = 1'b1;
        applyStimulus(1'b0, 24'h0, 24'h0);
        validB = 1'b0; leftB = 24'h0; rightB = 24'h0;
        lr131 = 1'b0; lr132 = 1'b0;
        step(3);
        checkOutput("rst_bclk", bclkA, 0);
        checkOutput("rst_lrclk", lrA, 1);
        checkOutput("rst_sdata", sdA, 0);
        checkOutput("rst_underrun", urA, 0);
        checkOutput("rst_ready", readyA, 1);

        $display("[TB] scenario 1: free-running framing, no input");
        rstA = 1'b0;
        step(1); checkOutput("s1_bclk_e1", bclkA, 0);
        step(1); checkOutput("s1_bclk_e2", bclkA, 1); checkOutput("s1_lr_e2", lrA, 1);
        step(1); checkOutput("s1_bclk_e3", bclkA, 1);
        step(1); checkOutput("s1_bclk_e4", bclkA, 0);
        checkOutput("s1_lr_fall_e4", lrA, 0);
        checkOutput("s1_underrun_e4", urA, 1);
        step(1); checkOutput("s1_underrun_e5", urA, 0);
        toggles = 0; urCount = 0; sdOnes = 0; prevBclk = bclkA;
        for (int e = 6; e <= 260; e++) begin
            step(1);
            if (bclkA != prevBclk) toggles++;
            prevBclk = bclkA;
            urCount += int'(urA);
            sdOnes  += int'(sdA);
            if (e == 131) lr131 = lrA;
            if (e == 132) lr132 = lrA;
        end
        checkOutput("s1_bclk_toggles", toggles, 128);
        checkOutput("s1_lr_before_rise", lr131, 0);
        checkOutput("s1_lr_rise_128", lr132, 1);
        checkOutput("s1_underrun_count", urCount, 1);
        checkOutput("s1_sdata_ones", sdOnes, 0);
        checkOutput("s1_lr_frame2", lrA, 0);

        $display("[TB] scenario 2: single transfer");
        applyStimulus(1'b1, 24'h800001, 24'h7FFFFF);
        step(1); checkOutput("s2_ready_drop", readyA, 0);
        applyStimulus(1'b0, 24'h0, 24'h0);
        step(254); checkOutput("s2_ready_held", readyA, 0);
        step(1);
        checkOutput("s2_no_underrun", urA, 0);
        checkOutput("s2_ready_return", readyA, 1);
        collectFrame(0, 64, 4, word, lrOnes, rdyOnes, urOnes);
        checkOutput("s2_frame", word, 64'h80000100_7FFFFF00);
        checkOutput("s2_lr_ones", lrOnes, 32);
        checkOutput("s2_ready_ones", rdyOnes, 64);
        checkOutput("s2_underrun_next", urA, 1);

        $display("[TB] scenario 3: back-to-back ramp");
        applyStimulus(1'b1, rampL(1), ~rampL(1));
        step(1); checkOutput("s3_ready_drop", readyA, 0);
        applyStimulus(1'b1, rampL(2), ~rampL(2));
        step(255);
        for (int k = 1; k <= 3; k++) begin
            checkOutput($sformatf("s3_underrun_f%0d", k), urA, 0);
            checkOutput($sformatf("s3_ready_f%0d", k), readyA, 1);
            collectFrame(0, 64, 4, word, lrOnes, rdyOnes, urOnes);
            checkOutput($sformatf("s3_frame_%0d", k), word,
                        {rampL(k), 8'h00, ~rampL(k), 8'h00});
            checkOutput($sformatf("s3_ready_ones_%0d", k), rdyOnes, 1);
            checkOutput($sformatf("s3_underruns_%0d", k), urOnes, 0);
            applyStimulus(1'b1, rampL(k + 2), ~rampL(k + 2));
        end
        applyStimulus(1'b0, 24'h0, 24'h0);

        $display("[TB] scenario 4: valid on frame-start cycle, buffer empty");
        step(255);
        applyStimulus(1'b1, 24'h123456, 24'hABCDEF);
        step(1);
        checkOutput("s4_underrun", urA, 1);
        checkOutput("s4_captured", readyA, 0);
        applyStimulus(1'b0, 24'h0, 24'h0);
        collectFrame(0, 64, 4, word, lrOnes, rdyOnes, urOnes);
        checkOutput("s4_zero_frame", word, 64'h0);
        checkOutput("s4_next_no_underrun", urA, 0);
        collectFrame(0, 64, 4, word, lrOnes, rdyOnes, urOnes);
        checkOutput("s4_next_frame", word, 64'h12345600_ABCDEF00);
        checkOutput("s4_underrun_after", urA, 1);

        $display("[TB] scenario 5: reset mid right slot with buffer full");
        applyStimulus(1'b1, 24'hFEDCBA, 24'h13579B);
        step(1);
        applyStimulus(1'b0, 24'h0, 24'h0);
        step(159);
        checkOutput("s5_in_right_slot", lrA, 1);
        checkOutput("s5_buffer_full", readyA, 0);
        rstA = 1'b1;
        step(1);
        checkOutput("s5_rst_bclk", bclkA, 0);
        checkOutput("s5_rst_lrclk", lrA, 1);
        checkOutput("s5_rst_sdata", sdA, 0);
        checkOutput("s5_rst_ready", readyA, 1);
        rstA = 1'b0;
        step(2); checkOutput("s5_bclk_e2", bclkA, 1);
        step(2);
        checkOutput("s5_bclk_e4", bclkA, 0);
        checkOutput("s5_lr_fall", lrA, 0);
        checkOutput("s5_underrun", urA, 1);
        collectFrame(0, 64, 4, word, lrOnes, rdyOnes, urOnes);
        checkOutput("s5_frame_empty", word, 64'h0);
        checkOutput("s5_underrun_next", urOnes, 1);

        $display("[TB] scenario 6: 24-bit slots, BCLK = clk/2");
        rstB = 1'b0; validB = 1'b1; leftB = 24'hC0FFEE; rightB = 24'h123456;
        step(1);
        checkOutput("s6_bclk_e1", bclkB, 1);
        checkOutput("s6_ready_drop", readyB, 0);
        validB = 1'b0;
        step(1);
        checkOutput("s6_bclk_e2", bclkB, 0);
        checkOutput("s6_lr_fall", lrB, 0);
        checkOutput("s6_no_underrun", urB, 0);
        collectFrame(1, 48, 2, word, lrOnes, rdyOnes, urOnes);
        checkOutput("s6_frame", word, 64'h0000_C0FFEE_123456);
        checkOutput("s6_lr_ones", lrOnes, 24);
        checkOutput("s6_lr_period", lrB, 0);
        checkOutput("s6_underrun_next", urB, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
